// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// AXI4-Lite manager/subordinate channel bundle; widths must match the arbiter.
interface axi4_lite_req_arbiter_if #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) ();

  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_req_arbiter_rr_arbiter.sv
// Round-robin grant: the first pending requester after the last winner wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic                       grant_en,
  output logic [NUM_REQ-1:0]         grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q;
  logic [CW-1:0]    cand;

  // Scan candidates starting just after the pointer, wrapping, keep the first hit.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!any_grant && req_valid[cand[IDX_W-1:0]]) begin
        any_grant                     = 1'b1;
        grant_idx                     = cand[IDX_W-1:0];
        grant_oh[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

  // Remember the last winner; reset points at the top index so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (grant_en) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite manager port among NUM_REQ requesters, one transaction at a time.
module axi4_lite_req_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(C_DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [C_DATA_WIDTH-1:0]             rsp_rdata,
  output logic [1:0]                          rsp_resp,
  axi4_lite_req_arbiter_if.master             m_axi
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  arb_state_e                state_q;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [C_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [NUM_REQ-1:0]        gnt_oh_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                rsp_resp_q;

  logic [NUM_REQ-1:0]        grant_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic                      any_grant;
  logic                      grant_en;
  logic                      aw_done;
  logic                      w_done;

  assign grant_en  = (state_q == IDLE) && any_grant;
  assign req_ready = grant_en ? grant_oh : '0;

  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req_valid (req_valid),
    .grant_en  (grant_en),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Transaction sequencer: grant, drive the AXI channels, capture and return the response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      gnt_oh_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_grant) begin
            addr_q   <= req_addr[grant_idx*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            wdata_q  <= req_wdata[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
            wstrb_q  <= req_wstrb[grant_idx*STRB_W +: STRB_W];
            gnt_oh_q <= grant_oh;
            if (req_write[grant_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (awvalid_q && m_axi.awready) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && m_axi.wready) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi.bvalid) begin
            rsp_resp_q  <= m_axi.bresp;
            rsp_valid_q <= gnt_oh_q;
            bready_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        RD_AR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi.rvalid) begin
            rsp_rdata_q <= m_axi.rdata;
            rsp_resp_q  <= m_axi.rresp;
            rsp_valid_q <= gnt_oh_q;
            rready_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule
